// File: rtl/a78_loader.sv
// a78_loader: strips and parses the 128-byte A78 header from the ioctl cart download
// and writes ROM bytes into cart ROM memory. Headerless images are replayed verbatim
// from a local buffer. Define A78_SIZE_CHECK_EN to add the size_mismatch output.
module a78_loader #(
    parameter int HDR_LEN = 128,
    parameter int ADDR_W  = 18
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic [9:0]        cart_flags,
    output logic [31:0]       cart_size,
    output logic              header_valid,
    output logic              load_done,
    output logic              overflow
`ifdef A78_SIZE_CHECK_EN
    ,
    output logic              size_mismatch
`endif
);
    localparam int CW = $clog2(HDR_LEN);
    localparam logic [CW:0] LAST = (CW+1)'(HDR_LEN - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_REPLAY = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WWAIT  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Expected signature character for header bytes 1..9 ("ATARI7800")
    function automatic logic [7:0] sig_char(input logic [3:0] i);
        case (i)
            4'd1, 4'd3: sig_char = "A";
            4'd2:       sig_char = "T";
            4'd4:       sig_char = "R";
            4'd5:       sig_char = "I";
            4'd6:       sig_char = "7";
            4'd7:       sig_char = "8";
            4'd8, 4'd9: sig_char = "0";
            default:    sig_char = 8'h00;
        endcase
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CW:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d;
    logic              wait_q, wait_d;
    logic [9:0]        flags_q, flags_d;
    logic [31:0]       csize_q, csize_d;
    logic [31:0]       hsize_q, hsize_d;
    logic [1:0]        thi_q, thi_d;
    logic [7:0]        tlo_q, tlo_d;
    logic              sig_ok_q, sig_ok_d;
    logic              hv_q, hv_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              full_q, full_d;
    logic [ADDR_W:0]   written_q, written_d;
    logic              dl_q, dl_d;
    logic              dl_rise, start, buf_we;
    logic [7:0]        hdr_mem [HDR_LEN];

    assign dl_rise = ioctl_download & ~dl_q;

    // Next-state logic: header parse, replay of buffered bytes, and write handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        wait_d    = wait_q;
        flags_d   = flags_q;
        csize_d   = csize_q;
        hsize_d   = hsize_q;
        thi_d     = thi_q;
        tlo_d     = tlo_q;
        sig_ok_d  = sig_ok_q;
        hv_d      = hv_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        full_d    = full_q;
        written_d = written_q;
        dl_d      = ioctl_download;
        start     = 1'b0;
        buf_we    = 1'b0;
        case (state_q)
            S_IDLE: start = dl_rise;
            S_HDR: begin
                if (!ioctl_download) begin
                    state_d = (cnt_q == '0) ? S_DONE : S_REPLAY;
                    wait_d  = (cnt_q != '0);
                    addr_d  = '0;
                end else if (ioctl_wr) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q >= 1 && cnt_q <= 9 && ioctl_dout != sig_char(cnt_q[3:0])) sig_ok_d = 1'b0;
                    if (cnt_q >= 49 && cnt_q <= 52) hsize_d = {hsize_q[23:0], ioctl_dout};
                    if (cnt_q == 53) thi_d = ioctl_dout[1:0];
                    if (cnt_q == 54) tlo_d = ioctl_dout;
                    if (cnt_q == LAST) begin
                        addr_d  = '0;
                        hv_d    = sig_ok_q;
                        flags_d = sig_ok_q ? {thi_q[0], thi_q[1], tlo_q} : 10'd0;
                        csize_d = sig_ok_q ? hsize_q : 32'd0;
                        state_d = sig_ok_q ? S_DATA : S_REPLAY;
                        wait_d  = !sig_ok_q;
                    end
                end
            end
            S_REPLAY: begin
                if (!wr_q) begin
                    data_d = hdr_mem[addr_q[CW-1:0]];
                    wr_d   = 1'b1;
                end else if (mem_ack) begin
                    wr_d      = 1'b0;
                    written_d = written_q + 1'b1;
                    addr_d    = addr_q + 1'b1;
                    if (addr_q + 1'b1 == ADDR_W'(cnt_q)) begin
                        wait_d  = 1'b0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!ioctl_download) state_d = S_DONE;
                else if (ioctl_wr && full_q) ovf_d = 1'b1;
                else if (ioctl_wr) begin
                    data_d  = ioctl_dout;
                    wr_d    = 1'b1;
                    wait_d  = 1'b1;
                    state_d = S_WWAIT;
                end
            end
            S_WWAIT: begin
                if (mem_ack) begin
                    wr_d      = 1'b0;
                    wait_d    = 1'b0;
                    written_d = written_q + 1'b1;
                    full_d    = &addr_q;
                    addr_d    = (&addr_q) ? addr_q : addr_q + 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                if (!hv_q || hsize_q == 32'd0) csize_d = 32'(written_q);
                start = dl_rise;
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d   = S_HDR;
            cnt_d     = '0;
            addr_d    = '0;
            data_d    = '0;
            wr_d      = 1'b0;
            wait_d    = 1'b0;
            flags_d   = '0;
            csize_d   = '0;
            hsize_d   = '0;
            thi_d     = '0;
            tlo_d     = '0;
            sig_ok_d  = 1'b1;
            hv_d      = 1'b0;
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            full_d    = 1'b0;
            written_d = '0;
        end
    end

    // State registers; dl_q resets high so a download held across reset needs a fresh rise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            wait_q    <= 1'b0;
            flags_q   <= '0;
            csize_q   <= '0;
            hsize_q   <= '0;
            thi_q     <= '0;
            tlo_q     <= '0;
            sig_ok_q  <= 1'b0;
            hv_q      <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            written_q <= '0;
            dl_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            wait_q    <= wait_d;
            flags_q   <= flags_d;
            csize_q   <= csize_d;
            hsize_q   <= hsize_d;
            thi_q     <= thi_d;
            tlo_q     <= tlo_d;
            sig_ok_q  <= sig_ok_d;
            hv_q      <= hv_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            written_q <= written_d;
            dl_q      <= dl_d;
        end
    end

    // Header buffer, kept for replay when the signature check fails
    always_ff @(posedge clock) begin
        if (buf_we) hdr_mem[cnt_q[CW-1:0]] <= ioctl_dout;
    end

    assign ioctl_wait   = wait_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_wr       = wr_q;
    assign cart_flags   = flags_q;
    assign cart_size    = csize_q;
    assign header_valid = hv_q;
    assign load_done    = done_q;
    assign overflow     = ovf_q;
`ifdef A78_SIZE_CHECK_EN
    assign size_mismatch = done_q & hv_q & (hsize_q != 32'd0) & (hsize_q != 32'(written_q));
`endif
endmodule

// File: tb/tb_a78_loader.sv
// tb_a78_loader: table-driven and randomized bench for a78_loader with a reference model
module tb_a78_loader;
    localparam int AW   = 10;
    localparam int MAXB = 1 << AW;

    logic          clock = 0;
    logic          reset_n = 1;
    logic          ioctl_download = 0;
    logic          ioctl_wr = 0;
    logic [7:0]    ioctl_dout = 0;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wr;
    logic          mem_ack = 0;
    logic [9:0]    cart_flags;
    logic [31:0]   cart_size;
    logic          header_valid, load_done, overflow;
`ifdef A78_SIZE_CHECK_EN
    logic          size_mismatch;
    bit            exp_mis;
`endif

    a78_loader #(.HDR_LEN(128), .ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .cart_flags(cart_flags), .cart_size(cart_size),
        .header_valid(header_valid), .load_done(load_done), .overflow(overflow)
`ifdef A78_SIZE_CHECK_EN
        , .size_mismatch(size_mismatch)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [31:0] hsize;
        logic [7:0]  thi;
        logic [7:0]  tlo;
        int          n;
        int          dly;
        logic        ehv;
        logic [9:0]  eflags;
        logic [31:0] esize;
        logic        eovf;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    vec_t       tbl[11];
    wr_t        got[$];
    wr_t        expw[$];
    logic [7:0] s[$];
    int         errors = 0;
    int         checks = 0;
    int         ack_dly = -1;
    int         stab_err = 0;
    bit         rst_test = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: records each write, acks after a delay, and sprinkles stray acks while idle
    initial begin : resp
        wr_t w;
        int  d;
        forever begin
            @(negedge clock);
            if (mem_wr === 1'b1) begin
                w.a = mem_addr;
                w.d = mem_data;
                got.push_back(w);
                mem_ack = 0;
                d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
                repeat (d) begin
                    @(negedge clock);
                    if (!rst_test && (mem_wr !== 1'b1 || mem_addr !== w.a || mem_data !== w.d)) stab_err++;
                end
                mem_ack = 1;
                @(negedge clock);
                mem_ack = 0;
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (ioctl_wait === 1'b1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, required 0", ioctl_wait, t);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        repeat ($urandom_range(0, 1)) @(negedge clock);
        wait_ready();
        ioctl_dout = b;
        ioctl_wr = 1;
        @(negedge clock);
        ioctl_wr = 0;
    endtask

    task automatic build(input vec_t v);
        logic [71:0] sig;
        logic [7:0]  b;
        sig = "ATARI7800";
        s.delete();
        if (v.kind == 0) begin
            for (int i = 0; i < v.n; i++) s.push_back(8'($urandom()));
        end else begin
            for (int i = 0; i < 128; i++) begin
                b = 8'($urandom());
                if (i >= 1 && i <= 9) b = sig[8*(9-i) +: 8];
                if (v.kind == 2 && i == 9) b = "1";
                if (i >= 49 && i <= 52) b = v.hsize[8*(52-i) +: 8];
                if (i == 53) b = v.thi;
                if (i == 54) b = v.tlo;
                s.push_back(b);
            end
            for (int i = 0; i < v.n; i++) s.push_back(8'($urandom()));
        end
    endtask

    // Reference: a valid header drops the first 128 bytes; everything else lands at
    // consecutive addresses from 0 until the memory is full
    task automatic model();
        logic [71:0] sig;
        bit          hv;
        int          base;
        wr_t         w;
        sig = "ATARI7800";
        hv = (s.size() >= 128);
        for (int i = 1; i <= 9; i++) if (i < s.size() && s[i] !== sig[8*(9-i) +: 8]) hv = 0;
        base = hv ? 128 : 0;
        expw.delete();
        for (int i = base; i < s.size(); i++) begin
            if (i - base < MAXB) begin
                w.a = AW'(i - base);
                w.d = s[i];
                expw.push_back(w);
            end
        end
`ifdef A78_SIZE_CHECK_EN
        begin
            logic [31:0] hs;
            hs = hv ? {s[49], s[50], s[51], s[52]} : 32'd0;
            exp_mis = hv && hs != 0 && hs != 32'(expw.size());
        end
`endif
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   t, bad, owb, base;
        v = tbl[k];
        build(v);
        model();
        got.delete();
        ack_dly = v.dly;
        owb = 0;
        base = (v.kind == 1) ? 128 : 0;
        ioctl_download = 0;
        repeat (2) @(negedge clock);
        ioctl_download = 1;
        repeat (2) @(negedge clock);
        chk($sformatf("v%0d_start_clear", k), {load_done, header_valid, overflow, cart_flags, cart_size}, 0);
        for (int i = 0; i < s.size(); i++) begin
            strobe(s[i]);
            if (i - base >= MAXB && ioctl_wait !== 1'b0) owb++;
            if (i == 127 && base == 0) begin
                t = 0;
                bad = 0;
                while (got.size() < 128 && t < 3000) begin
                    if (ioctl_wait !== 1'b1) bad++;
                    @(negedge clock);
                    t++;
                end
                chk($sformatf("v%0d_replay_wait_held", k), bad, 0);
            end
        end
        ioctl_download = 0;
        t = 0;
        while (load_done !== 1'b1 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        chk($sformatf("v%0d_load_done", k), load_done, 1);
        chk($sformatf("v%0d_header_valid", k), header_valid, v.ehv);
        chk($sformatf("v%0d_cart_flags", k), cart_flags, v.eflags);
        chk($sformatf("v%0d_cart_size", k), cart_size, v.esize);
        chk($sformatf("v%0d_overflow", k), overflow, v.eovf);
        chk($sformatf("v%0d_idle_handshake", k), {mem_wr, ioctl_wait}, 0);
        chk($sformatf("v%0d_write_count", k), got.size(), expw.size());
        bad = 0;
        for (int i = 0; i < got.size() && i < expw.size(); i++) if (got[i] !== expw[i]) bad++;
        chk($sformatf("v%0d_write_contents", k), bad, 0);
        if (v.eovf) chk($sformatf("v%0d_overflow_no_wait", k), owb, 0);
`ifdef A78_SIZE_CHECK_EN
        chk($sformatf("v%0d_size_mismatch", k), size_mismatch, exp_mis);
`endif
    endtask

    task automatic reset_mid();
        vec_t v;
        v = '{1, 32'h100, 8'h00, 8'h00, 200, -1, 1'b1, 10'h000, 32'h100, 1'b0};
        build(v);
        got.delete();
        ack_dly = -1;
        ioctl_download = 0;
        repeat (2) @(negedge clock);
        ioctl_download = 1;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 160; i++) strobe(s[i]);
        rst_test = 1;
        #2 reset_n = 0;
        #1;
        chk("rst_async_outputs", {ioctl_wait, mem_wr, mem_addr, mem_data, cart_flags, cart_size,
                                  header_valid, load_done, overflow}, 0);
        @(negedge clock);
        reset_n = 1;
        repeat (6) @(negedge clock);
        got.delete();
        for (int i = 0; i < 5; i++) strobe(8'hAA);
        repeat (10) @(negedge clock);
        chk("rst_idle_no_writes", got.size(), 0);
        chk("rst_idle_outputs", {ioctl_wait, mem_wr, cart_flags, cart_size, header_valid, load_done, overflow}, 0);
        rst_test = 0;
        ioctl_download = 0;
    endtask

    initial begin
        #1 reset_n = 0;
        repeat (3) @(negedge clock);
        chk("reset_state", {ioctl_wait, mem_wr, mem_addr, mem_data, cart_flags, cart_size,
                            header_valid, load_done, overflow}, 0);
        reset_n = 1;
        @(negedge clock);
        //         kind hsize      thi    tlo    n     dly ehv   eflags   esize      eovf
        tbl[0]  = '{1, 32'h200, 8'h00, 8'h01, 512,  2,  1'b1, 10'h001, 32'h200, 1'b0};
        tbl[1]  = '{0, 32'h0,   8'h00, 8'h00, 300,  -1, 1'b0, 10'h000, 32'd300, 1'b0};
        tbl[2]  = '{1, 32'h40,  8'h01, 8'h00, 64,   -1, 1'b1, 10'h200, 32'h40,  1'b0};
        tbl[3]  = '{1, 32'h0,   8'h02, 8'h05, 20,   -1, 1'b1, 10'h105, 32'd20,  1'b0};
        tbl[4]  = '{0, 32'h0,   8'h00, 8'h00, 50,   -1, 1'b0, 10'h000, 32'd50,  1'b0};
        tbl[5]  = '{1, 32'h400, 8'h03, 8'hA5, 1028, -1, 1'b1, 10'h3A5, 32'h400, 1'b1};
        tbl[6]  = '{0, 32'h0,   8'h00, 8'h00, 128,  -1, 1'b0, 10'h000, 32'd128, 1'b0};
        tbl[7]  = '{2, 32'h80,  8'h01, 8'h00, 72,   -1, 1'b0, 10'h000, 32'd200, 1'b0};
        tbl[8]  = '{0, 32'h0,   8'h00, 8'h00, 0,    -1, 1'b0, 10'h000, 32'd0,   1'b0};
        tbl[9]  = '{0, 32'h0,   8'h00, 8'h00, 1100, -1, 1'b0, 10'h000, 32'h400, 1'b1};
        tbl[10] = '{1, 32'h100, 8'h00, 8'h00, 128,  -1, 1'b1, 10'h000, 32'h100, 1'b0};
        for (int k = 0; k < 11; k++) run_vec(k);
        reset_mid();
        run_vec(4);
        chk("mem_handshake_stable", stab_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
